fc_cmd_arbiter: RTL

FC_CMD_ARBITER -- requirements
Module: fc_cmd_arbiter

---
 rtl/fc_cmd_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fc_cmd_arbiter.sv
// Two-requester command arbiter in front of the flash controller.
// Each requester has a 2-deep queue; grants are round-robin and each command runs one FC handshake.
`timescale 1ns/1ps
module fc_cmd_arbiter #(
  parameter int TIMEOUT = 4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  input  logic [32:0] r0_cmd,
  input  logic        r1_valid,
  input  logic [32:0] r1_cmd,
  output logic        r0_ready,
  output logic        r1_ready,
  output logic        r0_cpl,
  output logic        r1_cpl,
  output logic        r0_err,
  output logic        r1_err,
  output logic [32:0] fc_cmd,
  input  logic        fc_done,
  output logic        busy
);

  // state     | meaning
  // IDLE      | waiting for fc_done=1 and a queued command
  // ISSUE     | fc_cmd driven with the granted command for one cycle
  // WAIT_ACK  | waiting for the FC to drop fc_done
  // WAIT_DONE | waiting for the FC to raise fc_done again
  // RESP      | completion for the grantee is launched
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_RESP
  } state_t;

  localparam logic [11:0] TO_CNT = 12'(TIMEOUT);

  state_t      state_q;
  logic [32:0] issue_q;
  logic        gnt_q;
  logic        last_q;
  logic        err_pend_q;
  logic [11:0] tmo_q;
  logic [1:0]  cpl_q;
  logic [1:0]  err_q;

  logic [32:0] mem_q [2][2];
  logic [1:0]  cnt_q [2];
  logic [1:0]  wr_q;
  logic [1:0]  rd_q;

  logic [1:0]  valid;
  logic [1:0]  nempty;
  logic [1:0]  full;
  logic [1:0]  push;
  logic [1:0]  pop;
  logic [32:0] cmd_in [2];
  logic [32:0] head [2];
  logic        grant;
  logic        sel;
  logic [32:0] gcmd;
  logic [11:0] tmo_inc;
  logic        tmo_hit;

  assign valid     = {r1_valid, r0_valid};
  assign cmd_in[0] = r0_cmd;
  assign cmd_in[1] = r1_cmd;

  always_comb begin
    full   = '0;
    nempty = '0;
    push   = '0;
    for (int i = 0; i < 2; i++) begin
      full[i]   = (cnt_q[i] == 2'd2);
      nempty[i] = (cnt_q[i] != 2'd0);
      head[i]   = mem_q[i][rd_q[i]];
      push[i]   = valid[i] & ~full[i];
    end
  end

  // On a tie the requester not served last wins; otherwise whichever queue has work.
  always_comb begin
    grant = (state_q == S_IDLE) && fc_done && (|nempty);
    sel   = (&nempty) ? ~last_q : ~nempty[0];
    gcmd  = head[sel];
    pop   = '0;
    if (grant) pop[sel] = 1'b1;
  end

  assign tmo_inc = tmo_q + 12'd1;
  assign tmo_hit = (tmo_inc == TO_CNT);

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push[i]) mem_q[i][wr_q[i]] <= cmd_in[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_q[i] <= ~wr_q[i];
        if (pop[i])  rd_q[i] <= ~rd_q[i];
        cnt_q[i] <= cnt_q[i] + 2'(push[i]) - 2'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      issue_q    <= '0;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      err_pend_q <= 1'b0;
      tmo_q      <= '0;
      cpl_q      <= '0;
      err_q      <= '0;
    end else begin
      cpl_q <= '0;
      err_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            issue_q <= gcmd;
            gnt_q   <= sel;
            last_q  <= sel;
            if (gcmd == '0) begin
              err_pend_q <= 1'b1;
              state_q    <= S_RESP;
            end else begin
              err_pend_q <= 1'b0;
              state_q    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          tmo_q   <= '0;
          state_q <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (!fc_done) begin
            tmo_q   <= '0;
            state_q <= S_WAIT_DONE;
          end else if (tmo_hit) begin
            err_pend_q <= 1'b1;
            state_q    <= S_RESP;
          end else begin
            tmo_q <= tmo_inc;
          end
        end
        S_WAIT_DONE: begin
          if (fc_done) begin
            err_pend_q <= 1'b0;
            state_q    <= S_RESP;
          end else if (tmo_hit) begin
            err_pend_q <= 1'b1;
            state_q    <= S_RESP;
          end else begin
            tmo_q <= tmo_inc;
          end
        end
        S_RESP: begin
          cpl_q[gnt_q] <= 1'b1;
          err_q[gnt_q] <= err_pend_q;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign r0_ready = ~full[0];
  assign r1_ready = ~full[1];
  assign r0_cpl   = cpl_q[0];
  assign r1_cpl   = cpl_q[1];
  assign r0_err   = err_q[0];
  assign r1_err   = err_q[1];
  // Decoded from state so an async reset forces the bus to zero at once.
  assign fc_cmd   = (state_q == S_ISSUE) ? issue_q : '0;
  assign busy     = (state_q != S_IDLE);

endmodule
